// File: rtl/uart_servo_pkg.sv
// Shared command codes, reply framing, FSM encodings and helpers for the UART servo controller.
package uart_servo_pkg;

  localparam logic [7:0] CMD_SET_US   = 8'h01;
  localparam logic [7:0] CMD_ENABLE   = 8'h02;
  localparam logic [7:0] CMD_STATUS   = 8'h03;
  localparam logic [7:0] CMD_COUNTERS = 8'h04;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] LF  = 8'h0A;

  localparam int unsigned US_W  = 16;
  localparam int unsigned PWM_W = 20;

  typedef enum logic [1:0] {
    R_CMD  = 2'd0,
    R_HI   = 2'd1,
    R_LO   = 2'd2,
    R_TERM = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_LOAD    = 2'd1,
    T_WAIT_HI = 2'd2,
    T_WAIT_LO = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [15:0] data;
  } reply_t;

  // Limit a requested pulse width to the accepted range.
  function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] v,
                                               input logic [US_W-1:0] lo,
                                               input logic [US_W-1:0] hi);
    logic [US_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

  // Select byte idx of a reply frame: status, data_hi, data_lo, terminator.
  function automatic logic [7:0] reply_byte(input reply_t r, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = r.status;
      2'd1:    b = r.data[15:8];
      2'd2:    b = r.data[7:0];
      default: b = LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_reply_seq.sv
// One-entry reply register plus the TX byte sequencer using the transmitter busy handshake.
module uart_reply_seq
  import uart_servo_pkg::*;
(
  input  logic        clk,
  input  logic        reset_uart,
  input  logic        reply_load,
  input  logic [7:0]  reply_status,
  input  logic [15:0] reply_data,
  output logic        reply_busy,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data
);

  tx_state_t   state_q, state_d;
  reply_t      reply_q, reply_d;
  logic [1:0]  idx_q, idx_d;
  logic        tx_en_d;
  logic [7:0]  tx_data_d;
  logic        busy_d;

  // State and output registers; reset drops any pending reply immediately.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      state_q    <= T_IDLE;
      reply_q    <= '0;
      idx_q      <= 2'd0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      reply_busy <= 1'b0;
    end else begin
      state_q    <= state_d;
      reply_q    <= reply_d;
      idx_q      <= idx_d;
      tx_en      <= tx_en_d;
      tx_data    <= tx_data_d;
      reply_busy <= busy_d;
    end
  end

  // Next-state: accept a reply only when idle, then strobe four bytes through the busy handshake.
  always_comb begin
    state_d   = state_q;
    reply_d   = reply_q;
    idx_d     = idx_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data;
    case (state_q)
      T_IDLE: begin
        if (reply_load) begin
          reply_d.status = reply_status;
          reply_d.data   = reply_data;
          idx_d          = 2'd0;
          state_d        = T_LOAD;
        end
      end
      T_LOAD: begin
        if (!tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = reply_byte(reply_q, idx_q);
          state_d   = T_WAIT_HI;
        end
      end
      T_WAIT_HI: begin
        if (tx_busy) state_d = T_WAIT_LO;
      end
      T_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == 2'd3) begin
            state_d = T_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = T_LOAD;
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
    busy_d = (state_d != T_IDLE);
  end

endmodule

// File: rtl/uart_servo_ctrl.sv
// Frame parser and command executor between UART RX/TX byte streams and the servo PWM generator.
module uart_servo_ctrl
  import uart_servo_pkg::*;
#(
  parameter int unsigned CLK_PER_US        = 27,
  parameter int unsigned MIN_US            = 500,
  parameter int unsigned MAX_US            = 2500,
  parameter int unsigned DEFAULT_US        = 1500,
  parameter int unsigned FRAME_TIMEOUT_CYC = 2_700_000
)(
  input  logic             clk,
  input  logic             reset_uart,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic [PWM_W-1:0] pwm_width,
  output logic             pwm_enable,
  output logic [7:0]       err_cnt,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       control_leds
);

  localparam int unsigned TO_W = $clog2(FRAME_TIMEOUT_CYC + 1);

  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       cmd_q, hi_q, lo_q;
  logic [TO_W-1:0]  idle_q;
  logic [US_W-1:0]  us_q;
  logic [US_W-1:0]  set_us_c;
  logic             frame_end_c, accept_c, bad_term_c, timeout_c;
  logic             reply_load_c;
  logic [7:0]       reply_status_c;
  logic [15:0]      reply_data_c;
  logic             reply_busy;

  assign frame_end_c = (rx_state_q == R_TERM) && rx_valid;
  assign accept_c    = frame_end_c && (rx_data == LF);
  assign bad_term_c  = frame_end_c && (rx_data != LF);
  assign timeout_c   = (rx_state_q != R_CMD) && !rx_valid &&
                       (idle_q == TO_W'(FRAME_TIMEOUT_CYC - 1));
  assign set_us_c    = clamp_us({hi_q, lo_q}, US_W'(MIN_US), US_W'(MAX_US));

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset_uart) rx_state_q <= R_CMD;
    else            rx_state_q <= rx_state_d;
  end

  // RX next-state: advance on each byte; a timeout abandons the partial frame.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_CMD:  if (rx_valid) rx_state_d = R_HI;
      R_HI:   if (rx_valid) rx_state_d = R_LO;   else if (timeout_c) rx_state_d = R_CMD;
      R_LO:   if (rx_valid) rx_state_d = R_TERM; else if (timeout_c) rx_state_d = R_CMD;
      R_TERM: if (rx_valid) rx_state_d = R_CMD;  else if (timeout_c) rx_state_d = R_CMD;
      default: rx_state_d = R_CMD;
    endcase
  end

  // Latch frame bytes and track idle time inside a frame.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      cmd_q  <= 8'h00;
      hi_q   <= 8'h00;
      lo_q   <= 8'h00;
      idle_q <= '0;
    end else begin
      if (rx_valid) begin
        case (rx_state_q)
          R_CMD:   cmd_q <= rx_data;
          R_HI:    hi_q  <= rx_data;
          R_LO:    lo_q  <= rx_data;
          default: ;
        endcase
      end
      if (rx_state_q == R_CMD || rx_valid || timeout_c) idle_q <= '0;
      else                                              idle_q <= idle_q + TO_W'(1);
    end
  end

  // Build the reply for a completed frame from the pre-update register values.
  always_comb begin
    reply_load_c   = frame_end_c;
    reply_status_c = NAK;
    reply_data_c   = 16'h0000;
    if (accept_c) begin
      reply_status_c = ACK;
      case (cmd_q)
        CMD_SET_US:   reply_data_c = set_us_c;
        CMD_ENABLE:   reply_data_c = {15'b0, lo_q[0]};
        CMD_STATUS:   reply_data_c = us_q;
        CMD_COUNTERS: reply_data_c = {err_cnt, drop_cnt};
        default: begin
          reply_status_c = NAK;
          reply_data_c   = {cmd_q, 8'h00};
        end
      endcase
    end
  end

  // Apply accepted commands; the width product follows one cycle later.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      us_q         <= US_W'(DEFAULT_US);
      pwm_width    <= PWM_W'(DEFAULT_US * CLK_PER_US);
      pwm_enable   <= 1'b0;
      control_leds <= 8'h00;
    end else begin
      if (accept_c) begin
        control_leds <= cmd_q;
        case (cmd_q)
          CMD_SET_US: us_q       <= set_us_c;
          CMD_ENABLE: pwm_enable <= lo_q[0];
          default: ;
        endcase
      end
      pwm_width <= PWM_W'(32'(us_q) * CLK_PER_US);
    end
  end

  // Saturating error and dropped-reply counters.
  always_ff @(posedge clk) begin
    if (reset_uart) begin
      err_cnt  <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      if ((bad_term_c || timeout_c) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (reply_load_c && reply_busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  uart_reply_seq u_reply_seq (
    .clk          (clk),
    .reset_uart   (reset_uart),
    .reply_load   (reply_load_c),
    .reply_status (reply_status_c),
    .reply_data   (reply_data_c),
    .reply_busy   (reply_busy),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data)
  );

endmodule

// File: tb/tb_uart_servo_ctrl.sv
// Scoreboard bench: stimulus pushes expected reply bytes, a monitor checks every tx_en strobe.
module tb_uart_servo_ctrl;

  localparam int unsigned TIMEOUT  = 300;
  localparam int unsigned BUSY_CYC = 270;

  logic        clk = 1'b0;
  logic        reset_uart = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [19:0] pwm_width;
  logic        pwm_enable;
  logic [7:0]  err_cnt;
  logic [7:0]  drop_cnt;
  logic [7:0]  control_leds;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          busy_cnt = 0;
  logic        prev_en  = 1'b0;

  uart_servo_ctrl #(.FRAME_TIMEOUT_CYC(TIMEOUT)) dut (
    .clk          (clk),
    .reset_uart   (reset_uart),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_busy      (tx_busy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .pwm_width    (pwm_width),
    .pwm_enable   (pwm_enable),
    .err_cnt      (err_cnt),
    .drop_cnt     (drop_cnt),
    .control_leds (control_leds)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 10 us starting the cycle after each strobe.
  always @(posedge clk) begin
    if (tx_en)              busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor: every strobe must be single-cycle, issued while idle, and match the next expected byte.
  always @(negedge clk) begin
    if (tx_en) begin
      n_checks++;
      if (prev_en) begin
        n_fail++;
        $display("FAIL tx_en_width: tx_en high two cycles, got 1 required 0 at %0t", $time);
      end
      n_checks++;
      if (tx_busy) begin
        n_fail++;
        $display("FAIL tx_en_busy: tx_busy during strobe got 1 required 0 at %0t", $time);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got byte %02h, required no strobe at %0t", tx_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h required %02h at %0t", tx_data, e, $time);
        end
      end
    end
    prev_en = tx_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends a frame; returns 1 ns into cycle T+1 (T = terminator cycle).
  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] t);
    send_byte(c); repeat (2) @(posedge clk);
    send_byte(h); repeat (2) @(posedge clk);
    send_byte(l); repeat (2) @(posedge clk);
    send_byte(t);
  endtask

  task automatic expect_reply(input logic [7:0] s, input logic [7:0] h, input logic [7:0] l);
    exp_q.push_back(s);
    exp_q.push_back(h);
    exp_q.push_back(l);
    exp_q.push_back(8'h0A);
  endtask

  // Bounded wait until all expected bytes were strobed and the transmitter is idle.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL wait_idle: %0d bytes pending after %0d cycles, required 0", exp_q.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_pwm_width", 32'(pwm_width), 32'd40500);
    check("rst_pwm_enable", 32'(pwm_enable), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_leds", 32'(control_leds), 32'h00);
    reset_uart = 1'b0;
    repeat (2) @(posedge clk);

    // SET_US 1500
    expect_reply(8'h06, 8'h05, 8'hDC);
    send_frame(8'h01, 8'h05, 8'hDC, 8'h0A);
    check("set1500_leds", 32'(control_leds), 32'h01);
    @(posedge clk); #1;
    check("set1500_width", 32'(pwm_width), 32'd40500);
    wait_idle();

    // SET_US 100 clamps to 500; width lags leds by one cycle
    expect_reply(8'h06, 8'h01, 8'hF4);
    send_frame(8'h01, 8'h00, 8'h64, 8'h0A);
    check("set100_width_t1", 32'(pwm_width), 32'd40500);
    @(posedge clk); #1;
    check("set100_width_t2", 32'(pwm_width), 32'd13500);
    wait_idle();

    // SET_US 0xFFFF clamps to 2500
    expect_reply(8'h06, 8'h09, 8'hC4);
    send_frame(8'h01, 8'hFF, 8'hFF, 8'h0A);
    @(posedge clk); #1;
    check("setmax_width", 32'(pwm_width), 32'd67500);
    wait_idle();

    // ENABLE 1
    expect_reply(8'h06, 8'h00, 8'h01);
    send_frame(8'h02, 8'h00, 8'h01, 8'h0A);
    check("enable_on", 32'(pwm_enable), 32'd1);
    check("enable_leds", 32'(control_leds), 32'h02);
    wait_idle();

    // Unknown command: NAK, registers unchanged, leds updated
    expect_reply(8'h15, 8'h07, 8'h00);
    send_frame(8'h07, 8'h00, 8'h00, 8'h0A);
    check("unk_leds", 32'(control_leds), 32'h07);
    @(posedge clk); #1;
    check("unk_width", 32'(pwm_width), 32'd67500);
    check("unk_enable", 32'(pwm_enable), 32'd1);
    wait_idle();

    // Bad terminator
    expect_reply(8'h15, 8'h00, 8'h00);
    send_frame(8'h01, 8'h05, 8'hDC, 8'h41);
    check("badterm_err", 32'(err_cnt), 32'd1);
    @(posedge clk); #1;
    check("badterm_width", 32'(pwm_width), 32'd67500);
    wait_idle();

    // Timeout: partial frame, no reply
    send_byte(8'h01); repeat (2) @(posedge clk);
    send_byte(8'h05);
    repeat (290) @(posedge clk);
    #1;
    check("timeout_early_err", 32'(err_cnt), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("timeout_err", 32'(err_cnt), 32'd2);
    expect_reply(8'h06, 8'h09, 8'hC4);
    send_frame(8'h03, 8'h00, 8'h00, 8'h0A);
    check("post_timeout_leds", 32'(control_leds), 32'h03);
    wait_idle();

    // Back-to-back frames: second reply dropped, command still applied
    expect_reply(8'h06, 8'h03, 8'hE8);
    send_frame(8'h01, 8'h03, 8'hE8, 8'h0A);
    send_frame(8'h03, 8'h00, 8'h00, 8'h0A);
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("drop_leds", 32'(control_leds), 32'h03);
    check("drop_width", 32'(pwm_width), 32'd27000);
    wait_idle();

    // COUNTERS
    expect_reply(8'h06, 8'h02, 8'h01);
    send_frame(8'h04, 8'h00, 8'h00, 8'h0A);
    check("counters_leds", 32'(control_leds), 32'h04);
    wait_idle();

    // Reset in the middle of a reply
    expect_reply(8'h06, 8'h03, 8'hE8);
    send_frame(8'h03, 8'h00, 8'h00, 8'h0A);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 1 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("mid_reply_reached", 32'(n < 3000), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1;
    reset_uart = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("mrst_tx_en", 32'(tx_en), 32'd0);
    check("mrst_width", 32'(pwm_width), 32'd40500);
    check("mrst_enable", 32'(pwm_enable), 32'd0);
    check("mrst_err", 32'(err_cnt), 32'd0);
    check("mrst_drop", 32'(drop_cnt), 32'd0);
    check("mrst_leds", 32'(control_leds), 32'h00);
    reset_uart = 1'b0;
    repeat (800) @(posedge clk);
    #1;
    check("mrst_no_bytes_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
